// File: rtl/cpmath_pkg.sv
// Shared constants and types for the instruction fetch engine: state encoding,
// PC increment and instruction width.
package cpmath_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } fetch_state_t;

   localparam int PC_INC = 4;
   localparam int INST_W = 32;

   // Word-align a redirect target by clearing the byte offset.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Control-unit / memory / IR facing signals of the fetch engine.
// master = fetch engine side, slave = environment side.
interface instr_fetch_if #(parameter int ADDR_W = 32);
   import cpmath_pkg::*;

   logic              fetch_start;
   logic              pc_load;
   logic [ADDR_W-1:0] pc_next;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ready;
   logic [INST_W-1:0] mem_rdata;
   logic [INST_W-1:0] inst;
   logic              irWrite;
   logic [ADDR_W-1:0] pc;
   logic              busy;
   logic              fetch_err;

   modport master (
      input  fetch_start, pc_load, pc_next, mem_ready, mem_rdata,
      output mem_rd, mem_addr, inst, irWrite, pc, busy, fetch_err
   );

   modport slave (
      output fetch_start, pc_load, pc_next, mem_ready, mem_rdata,
      input  mem_rd, mem_addr, inst, irWrite, pc, busy, fetch_err
   );

endinterface

// File: rtl/instr_fetch_timer.sv
// Wait-cycle counter for an outstanding fetch; tc flags that the current
// non-ready cycle is the TIMEOUT-th one.
module fetch_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   logic [7:0] count_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (en) begin
         count_reg <= count_reg + 8'd1;
      end
   end

   assign tc = (count_reg == LAST);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch engine: owns the PC, issues one memory read per request,
// handles timeout and deferred redirects, and strobes irWrite for one cycle.
module instr_fetch
   import cpmath_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int                TIMEOUT  = 15
) (
   input logic          clk,
   input logic          reset,
   instr_fetch_if.master bus
);

   fetch_state_t      state_reg, state_next;
   logic [ADDR_W-1:0] prog_ctr_reg, prog_ctr_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic              rd_reg, rd_next;
   logic [INST_W-1:0] inst_reg, inst_next;
   logic              irw_reg, irw_next;
   logic              err_reg, err_next;
   logic              busy_reg;
   logic              pend_reg, pend_next;
   logic [ADDR_W-1:0] pend_pc_reg, pend_pc_next;

   logic              tmr_clr, tmr_en, tmr_tc;
   logic              redir;
   logic [ADDR_W-1:0] redir_pc;
   logic [ADDR_W-1:0] load_pc;

   assign load_pc = {bus.pc_next[ADDR_W-1:2], 2'b00};

   fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (tmr_clr),
      .en    (tmr_en),
      .tc    (tmr_tc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= S_IDLE;
         prog_ctr_reg <= RESET_PC;
         addr_reg     <= '0;
         rd_reg       <= 1'b0;
         inst_reg     <= '0;
         irw_reg      <= 1'b0;
         err_reg      <= 1'b0;
         busy_reg     <= 1'b0;
         pend_reg     <= 1'b0;
         pend_pc_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         prog_ctr_reg <= prog_ctr_next;
         addr_reg     <= addr_next;
         rd_reg       <= rd_next;
         inst_reg     <= inst_next;
         irw_reg      <= irw_next;
         err_reg      <= err_next;
         busy_reg     <= (state_next != S_IDLE);
         pend_reg     <= pend_next;
         pend_pc_reg  <= pend_pc_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      prog_ctr_next = prog_ctr_reg;
      addr_next     = addr_reg;
      rd_next       = rd_reg;
      inst_next     = inst_reg;
      irw_next      = 1'b0;
      err_next      = 1'b0;
      pend_next     = pend_reg;
      pend_pc_next  = pend_pc_reg;
      tmr_clr       = 1'b0;
      tmr_en        = 1'b0;
      redir         = pend_reg;
      redir_pc      = pend_pc_reg;

      case (state_reg)
         S_IDLE: begin
            if (bus.pc_load) begin
               prog_ctr_next = load_pc;
            end
            if (bus.fetch_start) begin
               // A simultaneous redirect wins: fetch from the new target.
               addr_next  = bus.pc_load ? load_pc : prog_ctr_reg;
               rd_next    = 1'b1;
               tmr_clr    = 1'b1;
               state_next = S_WAIT;
            end
         end

         S_WAIT: begin
            // A redirect arriving this very cycle supersedes any earlier one.
            if (bus.pc_load) begin
               redir    = 1'b1;
               redir_pc = load_pc;
            end
            if (bus.mem_ready) begin
               inst_next     = bus.mem_rdata;
               irw_next      = 1'b1;
               rd_next       = 1'b0;
               prog_ctr_next = redir ? redir_pc : prog_ctr_reg + ADDR_W'(PC_INC);
               pend_next     = 1'b0;
               state_next    = S_DONE;
            end else if (tmr_tc) begin
               rd_next    = 1'b0;
               err_next   = 1'b1;
               if (redir) begin
                  prog_ctr_next = redir_pc;
               end
               pend_next  = 1'b0;
               state_next = S_IDLE;
            end else begin
               tmr_en       = 1'b1;
               pend_next    = redir;
               pend_pc_next = redir_pc;
            end
         end

         S_DONE: begin
            if (bus.pc_load) begin
               prog_ctr_next = load_pc;
            end
            state_next = S_IDLE;
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign bus.mem_rd    = rd_reg;
   assign bus.mem_addr  = addr_reg;
   assign bus.inst      = inst_reg;
   assign bus.irWrite   = irw_reg;
   assign bus.pc        = prog_ctr_reg;
   assign bus.busy      = busy_reg;
   assign bus.fetch_err = err_reg;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch engine on the memory side of the instruction register. It supplies the 32-bit instruction word and the one-cycle irWrite strobe that the IR latches.
- Owns the PC: issues the read, waits on memory with a timeout, and presents the word together with irWrite.
- Advances the PC by 4 and supports a PC redirect from the control unit, which is deferred if it arrives mid-fetch.

Parameters:
- ADDR_W, 32, width of the PC and mem_addr.
- RESET_PC, 32'h0000_0000, PC value after reset.
- TIMEOUT, 15, maximum wait cycles for mem_ready before aborting; range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_start  in  1  control unit requests one instruction fetch.
- pc_load  in  1  redirect request; PC takes pc_next.
- pc_next  in  ADDR_W  redirect target; bits [1:0] are ignored and forced to 0.
- mem_rd  out  1  read request to instruction memory.
- mem_addr  out  ADDR_W  read address; stable while mem_rd=1.
- mem_ready  in  1  memory has valid data on mem_rdata this cycle.
- mem_rdata  in  32  memory read data.
- inst  out  32  instruction word to the IR.
- irWrite  out  1  IR write strobe, one cycle wide.
- pc  out  ADDR_W  current PC.
- busy  out  1  high in any state other than IDLE.
- fetch_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (asynchronous, active-high; outputs change without waiting for clk):
  - state=IDLE, pc=RESET_PC, mem_rd=0, mem_addr=0, inst=0.
  - irWrite=0, fetch_err=0, busy=0.
  - Wait counter = 0; pending-redirect flag cleared.
- All outputs are registered.
- States: IDLE, WAIT, DONE.
- IDLE:
  - pc_load alone: pc <= {pc_next[ADDR_W-1:2],2'b00}.
  - fetch_start alone: mem_addr <= pc, mem_rd <= 1, counter <= 0, go to WAIT.
  - pc_load and fetch_start together: the redirect wins. pc and mem_addr both take the aligned pc_next; the fetch proceeds from that address.
- WAIT:
  - mem_rd and mem_addr are held stable.
  - Counter increments each cycle mem_ready=0.
  - mem_ready=1:
    - inst <= mem_rdata, irWrite <= 1, mem_rd <= 0.
    - pc <= pending target if the pending flag is set, else pc+4. Clear the pending flag.
    - Go to DONE.
  - Counter reaches TIMEOUT with mem_ready=0:
    - mem_rd <= 0, fetch_err <= 1, pc unchanged.
    - Apply the pending redirect if set.
    - Go to IDLE.
  - mem_ready on the same cycle the counter hits TIMEOUT: data is accepted; no error.
  - pc_load during WAIT: the target is captured into the pending register; no effect on the in-flight address. The last pc_load seen wins.
  - fetch_start during WAIT is ignored.
- DONE:
  - irWrite=1 and inst valid for exactly this cycle; the IR captures at the next edge.
  - Next cycle: irWrite <= 0, go to IDLE. inst keeps its value until the next fetch completes.
  - fetch_start in DONE is ignored; the control unit re-asserts it in IDLE.
  - pc_load in DONE behaves as in IDLE, but does not start a fetch.
- Latency:
  - fetch_start sampled at edge 0 gives mem_rd=1 after edge 0.
  - mem_ready sampled at edge k gives inst/irWrite valid after edge k.
  - Zero-wait memory: fetch_start to irWrite is 2 cycles.
- Arithmetic: pc+4 wraps modulo 2^ADDR_W (32'hFFFF_FFFC -> 0).
- Reset mid-WAIT: mem_rd drops immediately; no irWrite, no fetch_err.

Decomposition:
- Shared package cpmath_pkg:
  - State encoding constants: S_IDLE=2'd0, S_WAIT=2'd1, S_DONE=2'd2.
  - PC_INC=4, INST_W=32.
- One natural sub-module: fetch_timer. It holds the wait counter with clear/enable inputs and a terminal-count output at TIMEOUT.
- The main FSM, PC and redirect logic stay in instr_fetch.

Test Plan:
- Reset then fetch_start, memory ready 1 cycle after mem_rd with mem_rdata=32'h8C41_0004:
  - mem_addr=0 at the read.
  - irWrite high for exactly 1 cycle with inst=32'h8C41_0004.
  - pc=4 afterwards.
- Three back-to-back fetches with 3-cycle memory latency:
  - mem_addr sequence 0, 4, 8; final pc=12.
  - mem_addr stable during each WAIT.
- pc_load=1 with pc_next=32'h0000_0103 and fetch_start in the same IDLE cycle:
  - mem_addr=32'h0000_0100.
  - pc=32'h0000_0104 after completion.
- pc_load with 32'h200 during WAIT (fetch at 0x10):
  - mem_addr stays 0x10.
  - After irWrite, pc=32'h200, not 0x14.
- mem_ready never asserted, TIMEOUT=15:
  - fetch_err pulses one cycle after 15 wait cycles.
  - mem_rd=0, pc unchanged, irWrite never asserted.
- reset asserted mid-WAIT at pc=0x40:
  - mem_rd=0 and pc=RESET_PC immediately, without a clock edge.
  - No irWrite or fetch_err pulse.
- Wrap-around: pc_load 32'hFFFF_FFFC, then fetch → pc=0.
